aes_decipher_block_param: RTL and testbench

Parametrised AES decipher round engine; successor to the fixed single-S-box decipher block in the AES core. It performs the initial, main and final inverse rounds over a 128-bit block. It supports 128-, 192- and 256-bit keys and a configurable number of parallel inverse S-box lanes, trading area for latency, and adds a synchronous abort. It sits between the core control and the external key memory, which supplies `round_key` for the round index the block presents on `round`.

---
 rtl/aes_decipher_block_param.sv | 237 +++++++++++++++++++++++
 tb/tb_aes_decipher_block_param.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_decipher_block_param.sv
// AES inverse round engine for 128/192/256-bit keys with 1, 2 or 4 parallel
// inverse S-box lanes; one 32-bit word per lane is substituted each SBOX cycle.

module aes_inv_sbox (
  input  logic [31:0] word,
  output logic [31:0] sub
);

  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_byte(input logic [7:0] b);
    int idx;
    idx = 2047 - 8 * int'(b);
    return INV_SBOX[idx -: 8];
  endfunction

  assign sub = {inv_byte(word[31:24]), inv_byte(word[23:16]),
                inv_byte(word[15:8]),  inv_byte(word[7:0])};

endmodule

module aes_decipher_block_param #(
  parameter int SBOX_LANES = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         next,
  input  logic         abort,
  input  logic [1:0]   keylen,
  output logic [3:0]   round,
  input  logic [127:0] round_key,
  input  logic [127:0] block,
  output logic [127:0] new_block,
  output logic         ready
);

  if (SBOX_LANES != 1 && SBOX_LANES != 2 && SBOX_LANES != 4) begin : g_bad_lanes
    $error("aes_decipher_block_param: SBOX_LANES must be 1, 2 or 4");
  end

  localparam logic [1:0] STEP = 2'(SBOX_LANES % 4);
  localparam logic [1:0] LAST = 2'(4 - SBOX_LANES);

  typedef enum logic [1:0] {IDLE, INIT, SBOX, MAIN} state_t;

  state_t       state, state_nxt;
  logic [31:0]  w [4];
  logic [1:0]   cnt;
  logic         done;

  logic         start, load_init, load_main, load_final, sub_en, do_abort;
  logic         load_all;
  logic [127:0] blk, added, init_val, main_val, load_val;

  logic [1:0]   lane_idx [SBOX_LANES];
  logic [31:0]  lane_in  [SBOX_LANES];
  logic [31:0]  lane_out [SBOX_LANES];

  function automatic logic [3:0] num_rounds(input logic [1:0] kl);
    case (kl)
      2'b01:   return 4'd14;
      2'b10:   return 4'd12;
      default: return 4'd10;
    endcase
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] imc_col(input logic [31:0] c);
    logic [7:0] a, m2, m4, m8;
    logic [7:0] e [4];
    logic [7:0] bb [4];
    logic [7:0] d [4];
    logic [7:0] n [4];
    for (int k = 0; k < 4; k++) begin
      a  = c[31-8*k -: 8];
      m2 = xt(a);
      m4 = xt(m2);
      m8 = xt(m4);
      e[k]  = m8 ^ m4 ^ m2;
      bb[k] = m8 ^ m2 ^ a;
      d[k]  = m8 ^ m4 ^ a;
      n[k]  = m8 ^ a;
    end
    return {e[0] ^ bb[1] ^ d[2] ^ n[3],
            n[0] ^ e[1]  ^ bb[2] ^ d[3],
            d[0] ^ n[1]  ^ e[2]  ^ bb[3],
            bb[0] ^ d[1] ^ n[2]  ^ e[3]};
  endfunction

  function automatic logic [127:0] inv_mix_cols(input logic [127:0] v);
    return {imc_col(v[127:96]), imc_col(v[95:64]), imc_col(v[63:32]), imc_col(v[31:0])};
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] v);
    logic [31:0] w0, w1, w2, w3;
    w0 = v[127:96];
    w1 = v[95:64];
    w2 = v[63:32];
    w3 = v[31:0];
    return {w0[31:24], w3[23:16], w2[15:8], w1[7:0],
            w1[31:24], w0[23:16], w3[15:8], w2[7:0],
            w2[31:24], w1[23:16], w0[15:8], w3[7:0],
            w3[31:24], w2[23:16], w1[15:8], w0[7:0]};
  endfunction

  assign blk      = {w[0], w[1], w[2], w[3]};
  assign added    = blk ^ round_key;
  assign init_val = inv_shift_rows(block ^ round_key);
  assign main_val = inv_shift_rows(inv_mix_cols(added));

  for (genvar j = 0; j < SBOX_LANES; j++) begin : g_lane
    assign lane_idx[j] = cnt + 2'(j);
    assign lane_in[j]  = w[lane_idx[j]];
    aes_inv_sbox u_sbox (.word(lane_in[j]), .sub(lane_out[j]));
  end

  always_comb begin
    state_nxt  = state;
    start      = 1'b0;
    load_init  = 1'b0;
    load_main  = 1'b0;
    load_final = 1'b0;
    sub_en     = 1'b0;
    do_abort   = 1'b0;
    case (state)
      IDLE: begin
        // While the result commit is pending ready is still low, so next waits.
        if (ready && next && !abort) begin
          start     = 1'b1;
          state_nxt = INIT;
        end
      end
      INIT: begin
        if (abort) begin
          do_abort  = 1'b1;
          state_nxt = IDLE;
        end else begin
          load_init = 1'b1;
          state_nxt = SBOX;
        end
      end
      SBOX: begin
        if (abort) begin
          do_abort  = 1'b1;
          state_nxt = IDLE;
        end else begin
          sub_en = 1'b1;
          if (cnt == LAST) state_nxt = MAIN;
        end
      end
      MAIN: begin
        if (abort) begin
          do_abort  = 1'b1;
          state_nxt = IDLE;
        end else if (round != 4'd0) begin
          load_main = 1'b1;
          state_nxt = SBOX;
        end else begin
          load_final = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      ready     <= 1'b1;
      round     <= 4'd0;
      cnt       <= 2'd0;
      done      <= 1'b0;
      new_block <= '0;
    end else begin
      state <= state_nxt;
      done  <= load_final;
      if (start) begin
        round <= num_rounds(keylen);
        ready <= 1'b0;
      end
      if (load_init || load_main) cnt <= 2'd0;
      if (sub_en) begin
        cnt <= cnt + STEP;
        if (cnt == LAST) round <= round - 4'd1;
      end
      // Plaintext reaches the output only once the final round has completed.
      if (done) begin
        new_block <= blk;
        ready     <= 1'b1;
      end
      if (do_abort) begin
        ready     <= 1'b1;
        round     <= 4'd0;
        cnt       <= 2'd0;
        new_block <= '0;
      end
    end
  end

  assign load_all = load_init | load_main | load_final;

  always_comb begin
    load_val = added;
    if (load_init)      load_val = init_val;
    else if (load_main) load_val = main_val;
  end

  always_ff @(posedge clk) begin
    if (load_all) begin
      for (int k = 0; k < 4; k++) w[k] <= load_val[127-32*k -: 32];
    end else if (sub_en) begin
      for (int j = 0; j < SBOX_LANES; j++) w[lane_idx[j]] <= lane_out[j];
    end
  end

endmodule

// File: tb/tb_aes_decipher_block_param.sv
// Directed bench for aes_decipher_block_param: FIPS-197 vectors at every lane
// count, with abort, reset and protocol-robustness steps on the single-lane build.

module tb_aes_decipher_block_param;

  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         nxt [3];
  logic         abt [3];
  logic [1:0]   kl  [3];
  logic [3:0]   rnd [3];
  logic [127:0] rk  [3];
  logic [127:0] blk [3];
  logic [127:0] nb  [3];
  logic         rdy [3];
  logic [127:0] sched [3][16];
  logic [7:0]   sb [256];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int t0, lat, ntrans, mono;
  logic [3:0] start_rnd;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rk[0] = sched[0][rnd[0]];
  assign rk[1] = sched[1][rnd[1]];
  assign rk[2] = sched[2][rnd[2]];

  aes_decipher_block_param #(.SBOX_LANES(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .next(nxt[0]), .abort(abt[0]), .keylen(kl[0]),
    .round(rnd[0]), .round_key(rk[0]), .block(blk[0]), .new_block(nb[0]), .ready(rdy[0]));
  aes_decipher_block_param #(.SBOX_LANES(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .next(nxt[1]), .abort(abt[1]), .keylen(kl[1]),
    .round(rnd[1]), .round_key(rk[1]), .block(blk[1]), .new_block(nb[1]), .ready(rdy[1]));
  aes_decipher_block_param #(.SBOX_LANES(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .next(nxt[2]), .abort(abt[2]), .keylen(kl[2]),
    .round(rnd[2]), .round_key(rk[2]), .block(blk[2]), .new_block(nb[2]), .ready(rdy[2]));

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00;
    x = a;
    y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // Forward S-box from field inverse plus affine map, for the key schedule.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] v);
    return {sb[v[31:24]], sb[v[23:16]], sb[v[15:8]], sb[v[7:0]]};
  endfunction

  task automatic load_keys(input int i, input logic [1:0] k, input logic [255:0] key);
    int nk, nr;
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    nk = (k == 2'b01) ? 8 : (k == 2'b10) ? 6 : 4;
    nr = nk + 6;
    rc = 8'h01;
    for (int j = 0; j < nk; j++) w[j] = key[255-32*j -: 32];
    for (int j = nk; j < 4 * (nr + 1); j++) begin
      t = w[j-1];
      if (j % nk == 0) begin
        t = subw({t[23:0], t[31:24]});
        t[31:24] = t[31:24] ^ rc;
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (nk > 6 && j % nk == 4) begin
        t = subw(t);
      end
      w[j] = w[j-nk] ^ t;
    end
    for (int r = 0; r < 16; r++)
      sched[i][r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start(input int i, input logic [1:0] k, input logic [127:0] ct);
    @(negedge clk);
    kl[i]  = k;
    blk[i] = ct;
    nxt[i] = 1'b1;
    @(posedge clk);
    #1;
    t0        = cyc;
    start_rnd = rnd[i];
    nxt[i]    = 1'b0;
  endtask

  task automatic wait_done(input int i);
    int guard;
    logic [3:0] prev;
    guard  = 0;
    ntrans = 0;
    mono   = 1;
    prev   = rnd[i];
    while (!rdy[i] && guard < 300) begin
      @(posedge clk);
      #1;
      guard++;
      if (rnd[i] != prev) begin
        if (rnd[i] != 4'(prev - 4'd1)) mono = 0;
        ntrans++;
        prev = rnd[i];
      end
    end
    lat = cyc - t0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nxt[i] = 1'b0;
      abt[i] = 1'b0;
      kl[i]  = 2'b00;
      blk[i] = '0;
    end
    build_sbox();
    load_keys(0, 2'b00, K128);
    load_keys(1, 2'b00, K128);
    load_keys(2, 2'b00, K128);

    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", 128'(rdy[0]), 128'd1);
    check("reset_round", 128'(rnd[0]), 128'd0);
    check("reset_block", nb[0], 128'h0);
    check("reset_ready_l4", 128'(rdy[2]), 128'd1);
    @(negedge clk);
    reset_n = 1'b1;

    start(0, 2'b00, C128);
    wait_done(0);
    check("aes128_l1_lat", 128'(lat), 128'd52);
    check("aes128_l1_pt", nb[0], PT);

    start(1, 2'b00, C128);
    wait_done(1);
    check("aes128_l2_lat", 128'(lat), 128'd32);
    check("aes128_l2_pt", nb[1], PT);

    start(2, 2'b00, C128);
    wait_done(2);
    check("aes128_l4_lat", 128'(lat), 128'd22);
    check("aes128_l4_pt", nb[2], PT);

    load_keys(1, 2'b10, K192);
    start(1, 2'b10, C192);
    wait_done(1);
    check("aes192_l2_lat", 128'(lat), 128'd38);
    check("aes192_l2_pt", nb[1], PT);

    load_keys(2, 2'b01, K256);
    start(2, 2'b01, C256);
    check("aes256_first_round", 128'(start_rnd), 128'd14);
    wait_done(2);
    check("aes256_l4_lat", 128'(lat), 128'd30);
    check("aes256_l4_pt", nb[2], PT);
    check("aes256_round_steps", 128'(ntrans), 128'd14);
    check("aes256_round_monotone", 128'(mono), 128'd1);
    check("aes256_round_end", 128'(rnd[2]), 128'd0);

    // Abort ten cycles into a run, then restart immediately.
    start(0, 2'b00, C128);
    repeat (9) @(posedge clk);
    @(negedge clk);
    abt[0] = 1'b1;
    @(posedge clk);
    #1;
    check("abort_ready", 128'(rdy[0]), 128'd1);
    check("abort_round", 128'(rnd[0]), 128'd0);
    check("abort_block", nb[0], 128'h0);
    abt[0] = 1'b0;
    start(0, 2'b00, C128);
    wait_done(0);
    check("after_abort_lat", 128'(lat), 128'd52);
    check("after_abort_pt", nb[0], PT);

    // A stray next mid-run must not restart or disturb the operation.
    start(0, 2'b00, C128);
    repeat (20) @(posedge clk);
    @(negedge clk);
    nxt[0] = 1'b1;
    @(negedge clk);
    nxt[0] = 1'b0;
    wait_done(0);
    check("midrun_next_lat", 128'(lat), 128'd52);
    check("midrun_next_pt", nb[0], PT);

    start(0, 2'b00, C128);
    repeat (15) @(posedge clk);
    @(negedge clk);
    kl[0] = 2'b01;
    wait_done(0);
    check("keylen_toggle_lat", 128'(lat), 128'd52);
    check("keylen_toggle_pt", nb[0], PT);
    kl[0] = 2'b00;

    @(negedge clk);
    nxt[0] = 1'b1;
    abt[0] = 1'b1;
    @(posedge clk);
    #1;
    check("next_abort_ready", 128'(rdy[0]), 128'd1);
    check("next_abort_round", 128'(rnd[0]), 128'd0);
    @(negedge clk);
    nxt[0] = 1'b0;
    abt[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("next_abort_idle", 128'(rdy[0]), 128'd1);
    check("next_abort_hold", nb[0], PT);

    start(0, 2'b11, C128);
    wait_done(0);
    check("keylen11_lat", 128'(lat), 128'd52);
    check("keylen11_pt", nb[0], PT);

    // One-cycle reset in the middle of a run.
    start(0, 2'b00, C128);
    repeat (15) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("midreset_ready", 128'(rdy[0]), 128'd1);
    check("midreset_round", 128'(rnd[0]), 128'd0);
    check("midreset_block", nb[0], 128'h0);
    @(negedge clk);
    reset_n = 1'b1;
    start(0, 2'b00, C128);
    wait_done(0);
    check("after_reset_lat", 128'(lat), 128'd52);
    check("after_reset_pt", nb[0], PT);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
